// File: rtl/spi_frame_responder.sv
// spi_frame_responder: SPI mode-0 flash stand-in answering READ (0x03), JEDEC ID (0x9F)
// and status (0x05) from a parallel-preloaded byte memory, oversampled on clk_50.
module spi_frame_responder #(
  parameter int          MEM_BYTES = 1024,
  parameter int          AW        = 10,
  parameter logic [23:0] JEDEC_ID  = 24'hEF4014
) (
  input  logic          clk_50,
  input  logic          rst_n,
  input  logic          spi_cs,
  input  logic          spi_sck,
  input  logic          spi_si,
  output logic          spi_so,
  input  logic          mem_we,
  input  logic [AW-1:0] mem_waddr,
  input  logic [7:0]    mem_wdata,
  output logic          busy,
  output logic [7:0]    last_cmd
);
  typedef enum logic [2:0] {IDLE, CMD, ADDR, DATA, ID, STAT, IGNORE} state_t;
  localparam int SW = AW > 8 ? AW : 8;
  logic [7:0] mem [MEM_BYTES];
  logic cs_s1_q, cs_s2_q, cs_prev_q;
  logic sck_s1_q, sck_s2_q, sck_prev_q;
  logic si_s1_q, si_s2_q;
  state_t state_q, state_d;
  logic [4:0] cnt_q, cnt_d;
  logic [SW-2:0] sh_q, sh_d;
  logic [SW-1:0] rx;
  logic [AW-1:0] addr_q, addr_d;
  logic [1:0] id_q, id_d;
  logic [6:0] out_q, out_d;
  logic so_q, so_d, busy_q;
  logic [7:0] last_q, last_d;
  logic [7:0] id_byte, load_byte;
  logic rise, fall, streaming;
  always_ff @(posedge clk_50) begin
    {cs_s2_q, cs_s1_q} <= {cs_s1_q, spi_cs};
    {sck_s2_q, sck_s1_q} <= {sck_s1_q, spi_sck};
    {si_s2_q, si_s1_q} <= {si_s1_q, spi_si};
    sck_prev_q <= sck_s2_q;
  end
  // Write port is independent of the FSM; a same-cycle load sees the old byte.
  always_ff @(posedge clk_50)
    if (mem_we) mem[mem_waddr] <= mem_wdata;
  assign rise      = sck_s2_q & ~sck_prev_q;
  assign fall      = ~sck_s2_q & sck_prev_q;
  assign rx        = {sh_q, si_s2_q};
  assign streaming = state_q == DATA || state_q == ID || state_q == STAT;
  assign id_byte   = id_q == 2'd0 ? JEDEC_ID[23:16] : id_q == 2'd1 ? JEDEC_ID[15:8] :
                     id_q == 2'd2 ? JEDEC_ID[7:0] : 8'h00;
  assign load_byte = state_q == DATA ? mem[addr_q] : state_q == ID ? id_byte : 8'h00;
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sh_d    = sh_q;
    addr_d  = addr_q;
    id_d    = id_q;
    out_d   = out_q;
    so_d    = so_q;
    last_d  = last_q;
    if (cs_s2_q) begin
      state_d = IDLE;
      cnt_d   = '0;
      so_d    = 1'b0;
    end else if (state_q == IDLE) begin
      // cs_prev_q resets low, so a CS held low across reset is not a fall.
      state_d = cs_prev_q ? CMD : IDLE;
      cnt_d   = '0;
    end else begin
      if (rise) begin
        sh_d  = rx[SW-2:0];
        cnt_d = cnt_q + 5'd1;
        if (state_q == CMD && cnt_q == 5'd7) begin
          last_d  = rx[7:0];
          cnt_d   = '0;
          id_d    = '0;
          state_d = rx[7:0] == 8'h03 ? ADDR : rx[7:0] == 8'h9F ? ID :
                    rx[7:0] == 8'h05 ? STAT : IGNORE;
        end
        if (state_q == ADDR && cnt_q == 5'd23) begin
          addr_d  = rx[AW-1:0];
          cnt_d   = '0;
          state_d = DATA;
        end
      end
      // Rising edges keep cnt_q counting, so its low bits mark each byte start.
      if (fall && streaming) begin
        if (cnt_q[2:0] == 3'd0) begin
          so_d   = load_byte[7];
          out_d  = load_byte[6:0];
          addr_d = state_q == DATA ? addr_q + AW'(1) : addr_q;
          id_d   = state_q == ID && id_q != 2'd3 ? id_q + 2'd1 : id_q;
        end else begin
          so_d  = out_q[6];
          out_d = {out_q[5:0], 1'b0};
        end
      end
    end
  end
  always_ff @(posedge clk_50) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      sh_q      <= '0;
      addr_q    <= '0;
      id_q      <= '0;
      out_q     <= '0;
      so_q      <= 1'b0;
      last_q    <= 8'h00;
      busy_q    <= 1'b0;
      cs_prev_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      sh_q      <= sh_d;
      addr_q    <= addr_d;
      id_q      <= id_d;
      out_q     <= out_d;
      so_q      <= so_d;
      last_q    <= last_d;
      busy_q    <= ~cs_s2_q;
      cs_prev_q <= cs_s2_q;
    end
  end
  assign spi_so   = so_q;
  assign busy     = busy_q;
  assign last_cmd = last_q;
endmodule
